// File: rtl/ddrphy_rd_align.sv
// ddrphy_rd_align: per-lane read-data deskew FIFOs that release a beat only
// when every byte lane has one, plus a read-latency training FSM that
// measures per-lane arrival time after a DFI read enable.

// Per-lane deskew FIFO. The head is always visible; the parent decides when
// all lanes pop together.
module ddrphy_rd_align_lane #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic          not_empty,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          do_push;

    assign full      = (occ == FULL_CNT);
    assign not_empty = (occ != '0);
    assign head      = mem[rd_ptr];
    // A full FIFO still accepts a push when the same cycle pops its head.
    assign do_push   = push & (~full | pop);

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and sticky overflow; clear wins over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push && full && !pop)
                ovf <= 1'b1;
        end
    end
endmodule

// Top: lane array, all-lane pop/output register and training FSM.
module ddrphy_rd_align #(
    parameter int NUM_LANES  = 8,
    parameter int LANE_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dfi_rddata_en,
    input  logic [NUM_LANES-1:0]            cap_valid,
    input  logic [NUM_LANES*2*LANE_W-1:0]   cap_data,
    input  logic                            flush,
    input  logic                            train_start,
    input  logic [CNT_W-1:0]                cfg_timeout,
    output logic                            dfi_rddata_valid,
    output logic [NUM_LANES*2*LANE_W-1:0]   dfi_rddata,
    output logic                            train_busy,
    output logic                            train_done,
    output logic                            train_err,
    output logic [NUM_LANES*CNT_W-1:0]      lane_lat,
    output logic [NUM_LANES-1:0]            ovf_err
);
    localparam int DW = 2 * LANE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EN,
        S_MEASURE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [NUM_LANES-1:0]            seen;
    logic [NUM_LANES-1:0]            seen_nxt;
    logic [NUM_LANES-1:0][CNT_W-1:0] lat_q;

    logic [NUM_LANES-1:0][DW-1:0]    cap_lane;
    logic [NUM_LANES-1:0][DW-1:0]    head;
    logic [NUM_LANES-1:0][DW-1:0]    rd_q;
    logic [NUM_LANES-1:0]            not_empty;
    logic [NUM_LANES-1:0]            push_en;
    logic                            enter_wait;
    logic                            fifo_clr;
    logic                            pop;

    assign cap_lane   = cap_data;
    assign dfi_rddata = rd_q;
    assign lane_lat   = lat_q;

    // Starting training drains stale data so measurement sees a clean slate.
    assign enter_wait = train_start & ((state == S_IDLE) | (state == S_ERR));
    assign fifo_clr   = flush | enter_wait;
    assign push_en    = cap_valid & {NUM_LANES{~train_busy & ~fifo_clr}};
    assign pop        = (&not_empty) & ~fifo_clr;
    assign seen_nxt   = seen | cap_valid;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ddrphy_rd_align_lane #(
            .DW    (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (fifo_clr),
            .push      (push_en[g]),
            .pop       (pop),
            .din       (cap_lane[g]),
            .head      (head[g]),
            .not_empty (not_empty[g]),
            .ovf       (ovf_err[g])
        );
    end

    // Aligned output register: valid one cycle after a pop, data held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dfi_rddata_valid <= 1'b0;
            rd_q             <= '0;
        end else begin
            dfi_rddata_valid <= pop;
            if (pop)
                rd_q <= head;
        end
    end

    // Training FSM with registered status outputs and per-lane latency capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            seen       <= '0;
            lat_q      <= '0;
            train_busy <= 1'b0;
            train_done <= 1'b0;
            train_err  <= 1'b0;
        end else begin
            train_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (train_start) begin
                        state      <= S_WAIT_EN;
                        train_busy <= 1'b1;
                    end
                end
                S_WAIT_EN: begin
                    if (dfi_rddata_en) begin
                        state <= S_MEASURE;
                        cnt   <= CNT_W'(1);
                        seen  <= '0;
                    end
                end
                S_MEASURE: begin
                    for (int i = 0; i < NUM_LANES; i++)
                        if (cap_valid[i] && !seen[i])
                            lat_q[i] <= cnt;
                    seen <= seen_nxt;
                    if (cnt != '1)
                        cnt <= cnt + 1'b1;
                    // Completion beats timeout; >= makes a zero timeout fire at once.
                    if (&seen_nxt) begin
                        state      <= S_DONE;
                        train_busy <= 1'b0;
                        train_done <= 1'b1;
                    end else if (cnt >= cfg_timeout) begin
                        state      <= S_ERR;
                        train_busy <= 1'b0;
                        train_err  <= 1'b1;
                        for (int i = 0; i < NUM_LANES; i++)
                            if (!seen_nxt[i])
                                lat_q[i] <= '1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERR: begin
                    if (train_start) begin
                        state      <= S_WAIT_EN;
                        train_busy <= 1'b1;
                        train_err  <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    train_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ddrphy_rd_align.md
DDRPHY_RD_ALIGN -- requirements
Module: ddrphy_rd_align

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 8: number of byte lanes.
REQ-002 The block SHALL have parameter LANE_W, default 8: DQ bits per lane per edge.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): per-lane deskew FIFO entries.
REQ-004 The block SHALL have parameter CNT_W, default 5: latency counter width.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low; clock clk.
REQ-007 dfi_rddata_en  in  1  DFI read enable from controller.
REQ-008 cap_valid  in  NUM_LANES  per-lane captured beat-pair valid from the DQS capture stage.
REQ-009 cap_data  in  NUM_LANES*2*LANE_W  per-lane {rise,fall}; lane i at [(i+1)*2*LANE_W-1 : i*2*LANE_W], rise in upper half.
REQ-010 flush  in  1  clear all FIFOs.
REQ-011 train_start  in  1  start read-latency training.
REQ-012 cfg_timeout  in  CNT_W  training timeout in cycles.
REQ-013 dfi_rddata_valid  out  1  aligned read data valid.
REQ-014 dfi_rddata  out  NUM_LANES*2*LANE_W  aligned read data, same lane packing as cap_data.
REQ-015 train_busy  out  1  training in progress.
REQ-016 train_done  out  1  one-cycle pulse on successful training.
REQ-017 train_err  out  1  sticky training timeout flag.
REQ-018 lane_lat  out  NUM_LANES*CNT_W  measured per-lane latency, lane i at [(i+1)*CNT_W-1 : i*CNT_W].
REQ-019 ovf_err  out  NUM_LANES  sticky per-lane FIFO overflow.

Function
REQ-020 Each lane SHALL own a FIFO_DEPTH-entry FIFO; push when cap_valid[i]=1, train_busy=0, flush=0.
REQ-021 Pop SHALL occur on all lanes simultaneously in a cycle where every lane FIFO is non-empty; no lane pops alone.
REQ-022 dfi_rddata_valid SHALL assert the cycle after a pop, with dfi_rddata = the popped heads; latency from last-arriving lane's push to valid = 2 cycles.
REQ-023 dfi_rddata SHALL hold its last value when dfi_rddata_valid=0.
REQ-024 Push to a full FIFO with no same-cycle pop SHALL drop the data and set ovf_err[i]; push and pop on a full FIFO in one cycle SHALL succeed with no error.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-026 flush=1 SHALL empty all FIFOs next cycle, dominate same-cycle push/pop, suppress dfi_rddata_valid next cycle, and leave ovf_err unchanged.
REQ-027 Training FSM states: IDLE, WAIT_EN, MEASURE, DONE, ERR.
REQ-028 IDLE -> WAIT_EN on train_start=1; train_start ignored in other states except ERR.
REQ-029 WAIT_EN: on dfi_rddata_en=1 -> MEASURE with cnt=1, seen mask cleared.
REQ-030 MEASURE: first cap_valid[i] with seen[i]=0 latches lane_lat[i]=cnt and sets seen[i]; cnt increments per cycle, saturating at 2^CNT_W-1.
REQ-031 MEASURE -> DONE when all seen bits set (including same-cycle captures); DONE lasts one cycle with train_done=1, then IDLE.
REQ-032 MEASURE -> ERR when cnt==cfg_timeout and not all seen; unseen lanes get lane_lat = all ones; train_err=1.
REQ-033 ERR SHALL hold until train_start=1 (-> WAIT_EN, train_err cleared); timeout takes priority over completion only if both occur in same cycle? No: completion wins.
REQ-034 train_busy=1 in WAIT_EN and MEASURE; FIFO pushes suppressed while busy; FIFOs flushed on entry to WAIT_EN.
REQ-035 cfg_timeout=0 SHALL cause ERR on first MEASURE cycle unless all lanes complete that cycle.

Reset
REQ-036 rst_n=0 at a rising edge SHALL empty FIFOs, set FSM=IDLE, cnt=0, and drive dfi_rddata_valid, dfi_rddata, train_busy, train_done, train_err, lane_lat, ovf_err to 0.
REQ-037 Reset mid-training or mid-burst SHALL abandon all state; no output pulse follows reset release.

Verification
REQ-038 Aligned read: all 8 lanes cap_valid same cycle, lane i data 16'hA0+i -> dfi_rddata_valid 2 cycles later, data lane i = 16'hA0+i.
REQ-039 Skew: lanes 0-3 at cycle T, lanes 4-7 at T+2 -> single valid at T+4, no partial output.
REQ-040 Overflow: lane 0 pushed 5 times, others empty -> ovf_err=8'h01, lane 0 holds first 4 entries.
REQ-041 Training: train_start, rddata_en, lane i cap_valid at cnt=3+(i%2) -> lane_lat {4,3,...}, train_done pulse once.
REQ-042 Timeout: cfg_timeout=6, lane 7 never valid -> ERR at cnt=6, lane_lat[7]=5'h1F, train_err=1 until next train_start.
REQ-043 Flush and reset: flush with 2 entries queued -> no valid; rst_n=0 during MEASURE -> all outputs 0 next cycle.
